// File: rtl/picorv32_core_if.sv
// Native valid/ready memory port shared by instruction fetch and data access.
//   mem_valid  request pending (driven by core)
//   mem_instr  1 = request is an instruction fetch
//   mem_addr   word-aligned byte address
//   mem_wdata  store data, lane-replicated
//   mem_wstrb  byte write strobes, 0000 = read
//   mem_ready  memory completes the request this cycle (driven by memory)
//   mem_rdata  read data, valid while mem_ready=1
interface picorv32_core_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NSTRB = XLEN / 8;

  logic             mem_valid;
  logic             mem_instr;
  logic             mem_ready;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [NSTRB-1:0] mem_wstrb;
  logic [XLEN-1:0]  mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv32_core.sv
// Multi-cycle RV32I core (no CSRs) with one shared valid/ready memory port.
// Sequence per instruction: FETCH -> EXEC -> (MEM for load/store) -> FETCH.
// ECALL/EBREAK/illegal encodings enter a terminal TRAP state.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-high reset
//   trap   sticky halt indicator
//   bus    picorv32_core_if.master memory port
// Optional build macro CATCH_MISALIGN_EN: trap on misaligned data accesses and
// misaligned taken jump/branch targets instead of truncating to the aligned word.
module picorv32_core #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
  parameter logic [31:0] STACKADDR      = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            trap,
  picorv32_core_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] insn_q, insn_d;
  logic            trap_q, trap_d;
  logic            valid_q, valid_d;
  logic            instr_q, instr_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [1:0]      off_q, off_d;

  logic [XLEN-1:0] regs [NREGS];
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  // Instruction fields
  logic [6:0]      opcode, f7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = insn_q[6:0];
  assign rd     = insn_q[11:7];
  assign f3     = insn_q[14:12];
  assign rs1    = insn_q[19:15];
  assign rs2    = insn_q[24:20];
  assign f7     = insn_q[31:25];
  assign imm_i  = {{20{insn_q[31]}}, insn_q[31:20]};
  assign imm_s  = {{20{insn_q[31]}}, insn_q[31:25], insn_q[11:7]};
  assign imm_b  = {{19{insn_q[31]}}, insn_q[31], insn_q[7], insn_q[30:25], insn_q[11:8], 1'b0};
  assign imm_u  = {insn_q[31:12], 12'b0};
  assign imm_j  = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12], insn_q[20], insn_q[30:21], 1'b0};

  logic [XLEN-1:0] rs1_val, rs2_val, pc_plus4;
  assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  // Shared ALU for OP and OP-IMM; SUB only exists in the register form
  logic [XLEN-1:0] alu_b, alu_out;
  logic [4:0]      shamt;
  always_comb begin
    alu_b   = (opcode == OP_OP) ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    alu_out = '0;
    case (f3)
      3'b000:  alu_out = (opcode == OP_OP && f7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_out = rs1_val << shamt;
      3'b010:  alu_out = XLEN'($signed(rs1_val) < $signed(alu_b));
      3'b011:  alu_out = XLEN'(rs1_val < alu_b);
      3'b100:  alu_out = rs1_val ^ alu_b;
      3'b101:  alu_out = f7[5] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110:  alu_out = rs1_val | alu_b;
      3'b111:  alu_out = rs1_val & alu_b;
      default: alu_out = '0;
    endcase
  end

  // Branch condition
  logic br_take;
  always_comb begin
    br_take = 1'b0;
    case (f3)
      3'b000:  br_take = (rs1_val == rs2_val);
      3'b001:  br_take = (rs1_val != rs2_val);
      3'b100:  br_take = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_take = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_take = (rs1_val < rs2_val);
      3'b111:  br_take = (rs1_val >= rs2_val);
      default: br_take = 1'b0;
    endcase
  end

  // Encoding legality; SYSTEM and unknown opcodes fall through to illegal
  logic legal;
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE: legal = 1'b1;
      OP_JALR:   legal = (f3 == 3'b000);
      OP_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011);
      OP_LOAD:   legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OP_STORE:  legal = f3 inside {3'b000, 3'b001, 3'b010};
      OP_IMM: begin
        case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OP_OP:     legal = (f7 == 7'b0000000) ||
                         ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      default:   legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] pc_tgt, jalr_tgt, ls_addr;
  assign pc_tgt   = pc_q + ((opcode == OP_JAL) ? imm_j : imm_b);
  assign jalr_tgt = (rs1_val + imm_i) & ~32'd1;
  assign ls_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  logic misalign;
`ifdef CATCH_MISALIGN_EN
  always_comb begin
    misalign = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE: begin
        case (f3[1:0])
          2'b10:   misalign = (ls_addr[1:0] != 2'b00);
          2'b01:   misalign = ls_addr[0];
          default: misalign = 1'b0;
        endcase
      end
      OP_JAL:    misalign = (pc_tgt[1:0] != 2'b00);
      OP_BRANCH: misalign = br_take && (pc_tgt[1:0] != 2'b00);
      OP_JALR:   misalign = jalr_tgt[1];
      default:   misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Load lane extraction; offsets within a half/word truncate when misaligned
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_data;
  assign ld_b = bus.mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_h = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
  always_comb begin
    case (f3)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'b0, ld_b};
      3'b101:  ld_data = {16'b0, ld_h};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    insn_d   = insn_q;
    trap_d   = trap_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    off_d    = off_q;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = '0;

    case (state_q)
      S_FETCH: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          instr_d = 1'b1;
          addr_d  = {pc_q[31:2], 2'b00};
          wstrb_d = 4'b0000;
        end else if (bus.mem_ready) begin
          valid_d = 1'b0;
          insn_d  = bus.mem_rdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (!legal || misalign) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_plus4;
          case (opcode)
            OP_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
            OP_AUIPC: begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
            OP_JAL:   begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = pc_tgt; end
            OP_JALR:  begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = jalr_tgt; end
            OP_BRANCH: if (br_take) pc_d = pc_tgt;
            OP_IMM, OP_OP: begin rf_we = 1'b1; rf_wdata = alu_out; end
            OP_LOAD, OP_STORE: begin
              // pc advances when the data transfer completes
              state_d = S_MEM;
              pc_d    = pc_q;
              valid_d = 1'b1;
              instr_d = 1'b0;
              addr_d  = {ls_addr[31:2], 2'b00};
              off_d   = ls_addr[1:0];
              wstrb_d = 4'b0000;
              if (opcode == OP_STORE) begin
                case (f3)
                  3'b000: begin
                    wdata_d = {4{rs2_val[7:0]}};
                    wstrb_d = 4'b0001 << ls_addr[1:0];
                  end
                  3'b001: begin
                    wdata_d = {2{rs2_val[15:0]}};
                    wstrb_d = 4'b0011 << {ls_addr[1], 1'b0};
                  end
                  default: begin
                    wdata_d = rs2_val;
                    wstrb_d = 4'b1111;
                  end
                endcase
              end
            end
            default: ;
          endcase
        end
      end

      S_MEM: begin
        if (valid_q && bus.mem_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_plus4;
          state_d = S_FETCH;
          if (opcode == OP_LOAD) begin
            rf_we    = 1'b1;
            rf_wdata = ld_data;
          end
        end
      end

      S_TRAP:  ;
      default: state_d = S_TRAP;
    endcase
  end

  // Control and bus registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PROGADDR_RESET;
      insn_q  <= '0;
      trap_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      trap_q  <= trap_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      off_q   <= off_d;
    end
  end

  // Register file; x0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[5'(i)] <= (i == 2 && STACKADDR != 32'hFFFF_FFFF) ? STACKADDR : '0;
      end
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  assign trap          = trap_q;
  assign bus.mem_valid = valid_q;
  assign bus.mem_instr = instr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
endmodule

// File: tb/tb_picorv32_core.sv
// Directed testbench for picorv32_core: a latency-configurable memory model
// logs every completed transfer; tests compare the log against hand-computed
// expectations.
module tb_picorv32_core;
  logic clk = 1'b0;
  logic reset;
  logic trap;

  always #5 clk = ~clk;

  picorv32_core_if bus ();

  picorv32_core #(
    .PROGADDR_RESET(32'h0000_0000),
    .STACKADDR     (32'hFFFF_FFFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .trap (trap),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] mem [1024];
  int          lat = 0;
  int          nchecks = 0;
  int          nerrors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: grants after 'lat' waiting cycles, logs the transfer
  initial begin
    int   wait_cnt;
    int   idx;
    txn_t t;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    wait_cnt      = 0;
    forever begin
      @(negedge clk);
      if (!bus.mem_valid) begin
        wait_cnt      = 0;
        bus.mem_ready = 1'b0;
      end else if (wait_cnt >= lat) begin
        idx           = int'(bus.mem_addr[11:2]);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[idx];
        t.addr  = bus.mem_addr;
        t.wdata = bus.mem_wdata;
        t.wstrb = bus.mem_wstrb;
        t.instr = bus.mem_instr;
        log_q.push_back(t);
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_wstrb[b]) mem[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        end
      end else begin
        wait_cnt++;
        bus.mem_ready = 1'b0;
      end
    end
  end

  task automatic hold_reset(input int latency);
    reset = 1'b1;
    lat   = latency;
    repeat (3) @(posedge clk);
    #1;
    log_q.delete();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic wait_txn(input string tag, input int n, input int budget);
    int cyc = 0;
    while (log_q.size() < n && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic check_txn(input string tag, input int idx, input logic [31:0] addr,
                           input logic [3:0] wstrb, input logic instr);
    txn_t t;
    t = (idx < log_q.size()) ? log_q[idx] : '0;
    check({tag, "_addr"}, t.addr, addr);
    check({tag, "_wstrb_instr"}, {27'd0, t.wstrb, t.instr}, {27'd0, wstrb, instr});
  endtask

  function automatic logic [31:0] txn_wdata(input int idx);
    return (idx < log_q.size()) ? log_q[idx].wdata : 32'hDEAD_BEEF;
  endfunction

  task automatic load_loop_prog();
    mem[0] = 32'h3fc00093;
    mem[1] = 32'h0000a023;
    mem[2] = 32'h0000a103;
    mem[3] = 32'h00110113;
    mem[4] = 32'h0020a023;
    mem[5] = 32'hff5ff06f;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    int cyc;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_instr;

    // Reset state
    hold_reset(0);
    @(negedge clk);
    check("rst_trap",  {31'd0, trap}, 32'd0);
    check("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_instr", {31'd0, bus.mem_instr}, 32'd0);
    check("rst_addr",  bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);

    // Loop program: store counter 0,1,2,3 to 0x3fc
    hold_reset(0);
    load_loop_prog();
    reset = 1'b0;
    wait_txn("loop_count", 20, 600);
    check_txn("loop_f0", 0, 32'h0, 4'b0000, 1'b1);
    check_txn("loop_f4", 1, 32'h4, 4'b0000, 1'b1);
    check_txn("loop_sw0", 2, 32'h3fc, 4'b1111, 1'b0);
    check("loop_sw0_data", txn_wdata(2), 32'd0);
    check_txn("loop_f8", 3, 32'h8, 4'b0000, 1'b1);
    check_txn("loop_lw", 4, 32'h3fc, 4'b0000, 1'b0);
    check_txn("loop_sw1", 7, 32'h3fc, 4'b1111, 1'b0);
    check("loop_sw1_data", txn_wdata(7), 32'd1);
    check("loop_sw2_data", txn_wdata(13), 32'd2);
    check("loop_sw3_data", txn_wdata(19), 32'd3);
    check_txn("loop_jmp_f8", 9, 32'h8, 4'b0000, 1'b1);
    check("loop_trap", {31'd0, trap}, 32'd0);

    // Illegal all-zero instruction traps after EXEC, then bus stays idle
    hold_reset(0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("illegal_trap", {31'd0, trap}, 32'd1);
    check("illegal_ntxn", 32'(log_q.size()), 32'd1);
    vcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_valid) vcount++;
    end
    check("illegal_idle", 32'(vcount), 32'd0);

    // SB to 0x101, then LB/LBU of the same byte stored out for inspection
    hold_reset(0);
    mem[0] = 32'h0AB00113;  // addi x2,x0,0xAB
    mem[1] = 32'h10100093;  // addi x1,x0,0x101
    mem[2] = 32'h00208023;  // sb   x2,0(x1)
    mem[3] = 32'h00008183;  // lb   x3,0(x1)
    mem[4] = 32'h0000C203;  // lbu  x4,0(x1)
    mem[5] = 32'h20302023;  // sw   x3,0x200(x0)
    mem[6] = 32'h20402223;  // sw   x4,0x204(x0)
    mem[7] = 32'h00100073;  // ebreak
    reset = 1'b0;
    wait_txn("sb_count", 13, 600);
    check_txn("sb", 3, 32'h100, 4'b0010, 1'b0);
    check("sb_data", txn_wdata(3), 32'hABABABAB);
    check_txn("lb_req", 5, 32'h100, 4'b0000, 1'b0);
    check_txn("lb_out", 9, 32'h200, 4'b1111, 1'b0);
    check("lb_value", txn_wdata(9), 32'hFFFFFFAB);
    check("lbu_value", txn_wdata(11), 32'h000000AB);
    repeat (8) @(posedge clk);
    #1;
    check("ebreak_trap", {31'd0, trap}, 32'd1);
    check("ebreak_ntxn", 32'(log_q.size()), 32'd13);

    // Slow memory: request must be held stable while waiting
    hold_reset(5);
    load_loop_prog();
    reset = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_valid && cyc < 20);
    check("slow_req_seen", {31'd0, bus.mem_valid}, 32'd1);
    s_addr  = bus.mem_addr;
    s_wdata = bus.mem_wdata;
    s_wstrb = bus.mem_wstrb;
    s_instr = bus.mem_instr;
    check("slow_first_addr", s_addr, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("slow_hold_valid", {31'd0, bus.mem_valid}, 32'd1);
      check("slow_hold_addr", bus.mem_addr, s_addr);
      check("slow_hold_wdata", bus.mem_wdata, s_wdata);
      check("slow_hold_ctl", {27'd0, bus.mem_wstrb, bus.mem_instr}, {27'd0, s_wstrb, s_instr});
    end
    wait_txn("slow_count", 3, 400);
    check_txn("slow_sw0", 2, 32'h3fc, 4'b1111, 1'b0);
    check("slow_sw0_data", txn_wdata(2), 32'd0);

    // Misaligned LW at 0x3fe
    hold_reset(0);
    mem[0] = 32'h3FE00093;  // addi x1,x0,0x3fe
    mem[1] = 32'h0000A103;  // lw   x2,0(x1)
    reset = 1'b0;
`ifdef CATCH_MISALIGN_EN
    repeat (20) @(posedge clk);
    #1;
    check("mis_trap", {31'd0, trap}, 32'd1);
    check("mis_ntxn", 32'(log_q.size()), 32'd2);
`else
    wait_txn("mis_count", 3, 200);
    check_txn("mis_lw", 2, 32'h3fc, 4'b0000, 1'b0);
    check("mis_trap", {31'd0, trap}, 32'd0);
`endif

    // Reset in the middle of a fetch aborts it
    hold_reset(1000);
    load_loop_prog();
    reset = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_valid && cyc < 20);
    check("midrst_req_seen", {31'd0, bus.mem_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", {31'd0, bus.mem_valid}, 32'd0);
    lat = 0;
    repeat (2) @(posedge clk);
    #1;
    log_q.delete();
    reset = 1'b0;
    wait_txn("midrst_count", 1, 50);
    check_txn("midrst_f0", 0, 32'h0, 4'b0000, 1'b1);
    check("midrst_trap", {31'd0, trap}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
